// File: rtl/timer_counter_pkg.sv
// Shared types for the prescaled timer/counter.
// Holds the FSM state encoding and the run-mode constants.
package timer_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock-enable prescaler: counts 0..div_i, emits tick_o at div_i.
// Ports: clk_i, rst_ni, en_i (count enable), clear_i (zero count),
//        div_i (divide value), tick_o (combinational tick).
module timer_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic [PRESC_WIDTH-1:0] div_i,
    output logic                   tick_o
);

    localparam logic [PRESC_WIDTH-1:0] P_ONE = PRESC_WIDTH'(1);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;

    // >= so that lowering div_i below the running count still ticks
    assign tick_o = en_i && (cnt_q >= div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + P_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_counter_prescaled.sv
// Prescaled up-counter with compare match, overflow and one-shot mode.
// Ports: clk_i, rst_ni, cfg_en_i/mode_i/presc_i/cmp_i, clear_i, load_i,
//        load_value_i -> counter_value_o, target_reached_o, ovf_o, busy_o.
// Build option: TIMER_PRESCALER_EN adds the timer_prescaler divider;
// without it every enabled RUN cycle is a tick and cfg_presc_i is unused.
module timer_counter_prescaled
    import timer_counter_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cfg_en_i,
    input  logic                   cfg_mode_i,
    input  logic [PRESC_WIDTH-1:0] cfg_presc_i,
    input  logic [CNT_WIDTH-1:0]   cfg_cmp_i,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic [CNT_WIDTH-1:0]   load_value_i,
    output logic [CNT_WIDTH-1:0]   counter_value_o,
    output logic                   target_reached_o,
    output logic                   ovf_o,
    output logic                   busy_o
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tr_q, tr_d;
    logic                 ovf_q, ovf_d;
    logic                 run_en;
    logic                 tick;
    logic                 match;

    // Leaving RUN takes effect immediately: no tick on the exit cycle
    assign run_en = (state_q == ST_RUN) && cfg_en_i;

`ifdef TIMER_PRESCALER_EN
    timer_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (run_en),
        .clear_i(clear_i | load_i),
        .div_i  (cfg_presc_i),
        .tick_o (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^cfg_presc_i;
    assign tick         = run_en;
`endif

    assign match = tick && (cnt_q == cfg_cmp_i);

    always_comb begin
        cnt_d = cnt_q;
        tr_d  = 1'b0;
        ovf_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_value_i;
        end else if (match) begin
            cnt_d = '0;
            tr_d  = 1'b1;
        end else if (tick) begin
            cnt_d = cnt_q + C_ONE;
            ovf_d = &cnt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!cfg_en_i) begin
                    state_d = ST_IDLE;
                end else if (match && !clear_i && !load_i
                             && cfg_mode_i == MODE_ONESHOT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (clear_i || load_i || !cfg_en_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tr_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tr_q    <= tr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign counter_value_o  = cnt_q;
    assign target_reached_o = tr_q;
    assign ovf_o            = ovf_q;
    assign busy_o           = (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_counter_prescaled.sv
// Scoreboard bench for timer_counter_prescaled (CNT_WIDTH=8).
// Expected per-cycle outputs are queued; a monitor pops and compares.
module tb_timer_counter_prescaled;

    localparam int CW = 8;
    localparam int PW = 8;
`ifdef TIMER_PRESCALER_EN
    localparam bit P_EN = 1'b1;
`else
    localparam bit P_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          tr;
        logic          ovf;
        logic          busy;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, mode, clear, load;
    logic [PW-1:0] presc;
    logic [CW-1:0] cmp, lval;
    logic [CW-1:0] cnt;
    logic          tr, ovf, busy;

    obs_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    passed = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    timer_counter_prescaled #(
        .CNT_WIDTH(CW),
        .PRESC_WIDTH(PW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .cfg_en_i        (en),
        .cfg_mode_i      (mode),
        .cfg_presc_i     (presc),
        .cfg_cmp_i       (cmp),
        .clear_i         (clear),
        .load_i          (load),
        .load_value_i    (lval),
        .counter_value_o (cnt),
        .target_reached_o(tr),
        .ovf_o           (ovf),
        .busy_o          (busy)
    );

    task automatic chk(input string nm, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got cnt=%h tr=%b ovf=%b busy=%b, want cnt=%h tr=%b ovf=%b busy=%b",
                     nm, a.cnt, a.tr, a.ovf, a.busy, e.cnt, e.tr, e.ovf, e.busy);
        end else begin
            passed++;
        end
    endtask

    // Monitor: outputs settle #1 after each rising edge
    initial begin
        obs_t  e;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, {cnt, tr, ovf, busy}, e);
            end
        end
    end

    // Inputs are driven at negedge; expectation is for the next edge
    task automatic step(input string nm, input logic [CW-1:0] c,
                        input logic t, input logic o, input logic b);
        exp_q.push_back({c, t, o, b});
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int d;
        logic [CW-1:0] cur;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
        presc = '0;
        cmp   = '0;
        lval  = '0;
        #1;
        chk("rst_t0", {cnt, tr, ovf, busy}, '0);
        @(negedge clk);
        step("rst_hold", 8'h00, 0, 0, 0);
        step("rst_hold", 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        step("idle", 8'h00, 0, 0, 0);

        // Continuous, presc=0, cmp=3
        en = 1'b1;
        cmp = 8'd3;
        step("A_enter", 8'h00, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            for (int v = 1; v <= 3; v++) begin
                step("A_cnt", 8'(v), 0, 0, 1);
            end
            step("A_match", 8'h00, 1, 0, 1);
        end
        step("A_cnt", 8'h01, 0, 0, 1);
        en = 1'b0;
        step("A_pause", 8'h01, 0, 0, 0);
        step("A_pause", 8'h01, 0, 0, 0);
        en = 1'b1;
        step("A_resume", 8'h01, 0, 0, 1);
        step("A_cnt", 8'h02, 0, 0, 1);
        clear = 1'b1;
        step("A_clear", 8'h00, 0, 0, 1);
        clear = 1'b0;

        // presc=2, cmp=1
        presc = 8'd2;
        cmp = 8'd1;
        d = P_EN ? 3 : 1;
        cur = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < d - 1; j++) begin
                step("B_hold", cur, 0, 0, 1);
            end
            if (cur == 8'd1) begin
                cur = '0;
                step("B_match", cur, 1, 0, 1);
            end else begin
                cur = cur + 8'd1;
                step("B_tick", cur, 0, 0, 1);
            end
        end

        // Wrap through all-ones, cmp below count
        presc = '0;
        cmp = 8'h10;
        load = 1'b1;
        lval = 8'hFE;
        step("C_load", 8'hFE, 0, 0, 1);
        load = 1'b0;
        step("C_ff", 8'hFF, 0, 0, 1);
        step("C_wrap", 8'h00, 0, 1, 1);
        for (int v = 1; v <= 16; v++) begin
            step("C_cnt", 8'(v), 0, 0, 1);
        end
        step("C_match", 8'h00, 1, 0, 1);

        // clear/load against a matching tick
        cmp = 8'd3;
        for (int v = 1; v <= 3; v++) step("E_cnt", 8'(v), 0, 0, 1);
        clear = 1'b1;
        load = 1'b1;
        lval = 8'h55;
        step("E_clr_ld", 8'h00, 0, 0, 1);
        clear = 1'b0;
        load = 1'b0;
        for (int v = 1; v <= 3; v++) step("E_cnt", 8'(v), 0, 0, 1);
        load = 1'b1;
        step("E_load", 8'h55, 0, 0, 1);
        load = 1'b0;
        step("E_after", 8'h56, 0, 0, 1);

        // One-shot, cmp=5
        en = 1'b0;
        clear = 1'b1;
        step("F_stop", 8'h00, 0, 0, 0);
        clear = 1'b0;
        mode = 1'b1;
        cmp = 8'd5;
        en = 1'b1;
        step("F_enter", 8'h00, 0, 0, 1);
        for (int v = 1; v <= 5; v++) step("F_cnt", 8'(v), 0, 0, 1);
        step("F_match", 8'h00, 1, 0, 0);
        for (int k = 0; k < 3; k++) step("F_done", 8'h00, 0, 0, 0);
        clear = 1'b1;
        step("F_clr", 8'h00, 0, 0, 0);
        clear = 1'b0;
        step("F_rerun", 8'h00, 0, 0, 1);
        step("F_cnt", 8'h01, 0, 0, 1);

        // Reset mid-count, presc=3
        mode = 1'b0;
        cmp = 8'h80;
        presc = 8'd3;
        clear = 1'b1;
        step("G_clr", 8'h00, 0, 0, 1);
        clear = 1'b0;
        d = P_EN ? 4 : 1;
        cur = '0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < d - 1; j++) step("G_hold", cur, 0, 0, 1);
            cur = cur + 8'd1;
            step("G_tick", cur, 0, 0, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("G_rst_async", {cnt, tr, ovf, busy}, '0);
        @(negedge clk);
        step("G_rst_hold", 8'h00, 0, 0, 0);
        step("G_rst_hold", 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        step("G_enter", 8'h00, 0, 0, 1);
        for (int j = 0; j < d - 1; j++) step("G_wait", 8'h00, 0, 0, 1);
        step("G_first", 8'h01, 0, 0, 1);

        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timer_counter_prescaled.md
TIMER_COUNTER_PRESCALED -- requirements
Module: timer_counter_prescaled

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, counter and compare width (1..32).
REQ-002 SHALL have parameter PRESC_WIDTH, default 8, prescaler divide-value width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_en_i  input  1  run enable; low pauses the counter.
REQ-006 SHALL have port cfg_mode_i  input  1  0 = continuous (auto-reload), 1 = one-shot.
REQ-007 SHALL have port cfg_presc_i  input  PRESC_WIDTH  divide value; tick every cfg_presc_i+1 enabled cycles.
REQ-008 SHALL have port cfg_cmp_i  input  CNT_WIDTH  compare value.
REQ-009 SHALL have port clear_i  input  1  one-cycle request to zero the counter and the prescaler.
REQ-010 SHALL have port load_i  input  1  one-cycle request to load load_value_i.
REQ-011 SHALL have port load_value_i  input  CNT_WIDTH  value for load_i.
REQ-012 SHALL have port counter_value_o  output  CNT_WIDTH  registered count.
REQ-013 SHALL have port target_reached_o  output  1  registered one-cycle match pulse.
REQ-014 SHALL have port ovf_o  output  1  registered one-cycle pulse on wrap from all-ones to 0.
REQ-015 SHALL have port busy_o  output  1  high while state is RUN (decoded from the state register).

Function
REQ-016 SHALL implement states IDLE, RUN and DONE.
REQ-017 Transitions: IDLE->RUN when cfg_en_i=1; RUN->IDLE when cfg_en_i=0 (count and prescaler held); RUN->DONE on a match when cfg_mode_i=1; DONE->IDLE on clear_i, load_i or cfg_en_i=0.
REQ-018 Prescaler SHALL count only in RUN, from 0 to cfg_presc_i, and assert an internal tick at cfg_presc_i, returning to 0 on the same edge; cfg_presc_i=0 SHALL give a tick every cycle.
REQ-019 A tick with counter_value_o==cfg_cmp_i SHALL be a match: the counter SHALL go to 0 on that edge, and target_reached_o SHALL be 1 for the following cycle only.
REQ-020 A tick without a match SHALL increment the counter modulo 2^CNT_WIDTH; a wrap from all-ones SHALL pulse ovf_o for one cycle.
REQ-021 Period in continuous mode SHALL be (cfg_cmp_i+1)*(cfg_presc_i+1) cycles between target_reached_o pulses; cfg_cmp_i=0 SHALL give a match on every tick.
REQ-022 If cfg_cmp_i is lowered below the current count, the counter SHALL run to all-ones, wrap with ovf_o, then match normally.
REQ-023 One-shot: on a match, the counter SHALL go to 0, the block SHALL enter DONE, and the counter SHALL hold 0 until DONE is left.
REQ-024 Priority SHALL be clear_i > load_i > tick; clear_i or load_i SHALL zero the prescaler and suppress any target_reached_o or ovf_o that the same cycle's tick would have produced.
REQ-025 clear_i and load_i SHALL act in every state, including IDLE.
REQ-026 cfg_* changes SHALL take effect on the next cycle with no restart required.

Reset
REQ-027 While rst_ni=0: state=IDLE, prescaler=0, counter_value_o=0, target_reached_o=0, ovf_o=0, busy_o=0, independent of clk_i.
REQ-028 Reset mid-count SHALL discard all progress; after release the block SHALL stay in IDLE until it samples cfg_en_i=1.

Configuration
REQ-029 Macro TIMER_PRESCALER_EN defined: the prescaler SHALL be built as in REQ-018.
REQ-030 Macro TIMER_PRESCALER_EN undefined: there SHALL be no prescaler logic, every RUN cycle SHALL be a tick, and cfg_presc_i SHALL be ignored (port kept).

Structure
REQ-031 Package timer_counter_pkg SHALL hold the state enum and the mode constants MODE_CONT=1'b0 and MODE_ONESHOT=1'b1.
REQ-032 The prescaler SHALL be the sub-module timer_prescaler (inputs: clk_i, rst_ni, enable, clear, divide value; output: tick), instantiated only under TIMER_PRESCALER_EN.

Verification
REQ-033 presc=0, cmp=3, continuous, en=1 -> count sequence 0,1,2,3,0; target_reached_o pulses every 4 cycles.
REQ-034 presc=2, cmp=1, continuous -> count changes every 3 cycles; target_reached_o period 6 cycles.
REQ-035 one-shot, presc=0, cmp=5 -> single pulse 6 cycles after en; then DONE, busy_o=0, count held 0; clear_i -> IDLE then RUN.
REQ-036 CNT_WIDTH=8, load 0xFE, cmp=0x10 -> 0xFE, 0xFF, 0x00 with one ovf_o pulse, then target_reached_o at count 0x10.
REQ-037 clear_i and load_i in the same cycle as a matching tick -> count 0, no target_reached_o; load_i alone on a matching tick -> count=load_value_i, no pulse.
REQ-038 rst_ni asserted mid-count with presc=3 -> all outputs 0 immediately; after release with en=1, first increment 4 cycles after entering RUN.
